// File: rtl/aes128_pkg.sv
// Shared constants, FSM state type, S-box table and GF(2^8) helper for the
// AES-128 key-schedule engine.
package aes128_pkg;

  localparam int NK = 4;
  localparam int NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Forward AES S-box, indexed by the input byte
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte AES S-box lookup.
module aes_sbox
  import aes128_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] subst
);

  assign subst = SBOX[data];

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into eleven
// output registers, sk0 loaded from the cipher key at accept.
module aes128_key_expand
  import aes128_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in_key,
  output logic         busy,
  output logic         valid,
  output logic [127:0] sk0,
  output logic [127:0] sk1,
  output logic [127:0] sk2,
  output logic [127:0] sk3,
  output logic [127:0] sk4,
  output logic [127:0] sk5,
  output logic [127:0] sk6,
  output logic [127:0] sk7,
  output logic [127:0] sk8,
  output logic [127:0] sk9,
  output logic [127:0] sk10
);

  state_t state, state_next;
  logic [3:0] round, round_next;
  logic [7:0] rcon, rcon_next;
  logic valid_next;
  logic accept;

  logic [32*NK-1:0] keys [NR+1];
  logic [32*NK-1:0] prev;
  logic [32*NK-1:0] round_key;
  logic [31:0] rot, sub, t;
  logic [31:0] w0, w1, w2, w3;

  assign busy   = (state == ST_RUN);
  assign accept = (state == ST_IDLE) && start;

  // Previous round key comes straight from its register
  always_comb begin
    prev = '0;
    for (int i = 0; i < NR; i++) begin
      if (round == 4'(i + 1)) prev = keys[i];
    end
  end

  assign rot = {prev[23:0], prev[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    aes_sbox u_sbox (
      .data  (rot[gi*8 +: 8]),
      .subst (sub[gi*8 +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign w0 = prev[127:96] ^ t;
  assign w1 = prev[95:64]  ^ w0;
  assign w2 = prev[63:32]  ^ w1;
  assign w3 = prev[31:0]   ^ w2;
  assign round_key = {w0, w1, w2, w3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      round <= '0;
      rcon  <= RCON_INIT;
      valid <= 1'b0;
    end else begin
      state <= state_next;
      round <= round_next;
      rcon  <= rcon_next;
      valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    round_next = round;
    rcon_next  = rcon;
    valid_next = valid;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          round_next = 4'd1;
          rcon_next  = RCON_INIT;
          valid_next = 1'b0;
        end
      end
      ST_RUN: begin
        round_next = round + 4'd1;
        rcon_next  = xtime(rcon);
        if (round == 4'(NR)) begin
          state_next = ST_IDLE;
          valid_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) keys[i] <= '0;
    end else if (accept) begin
      keys[0] <= in_key;
    end else if (state == ST_RUN) begin
      for (int i = 1; i <= NR; i++) begin
        if (round == 4'(i)) keys[i] <= round_key;
      end
    end
  end

  assign sk0  = keys[0];
  assign sk1  = keys[1];
  assign sk2  = keys[2];
  assign sk3  = keys[3];
  assign sk4  = keys[4];
  assign sk5  = keys[5];
  assign sk6  = keys[6];
  assign sk7  = keys[7];
  assign sk8  = keys[8];
  assign sk9  = keys[9];
  assign sk10 = keys[10];

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed and random checks of aes128_key_expand against a word-level
// FIPS-197 key expansion with an S-box derived from GF(2^8) inversion.
module tb_aes128_key_expand;

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [127:0] in_key;
  logic busy;
  logic valid;
  logic [127:0] sk_out [11];

  logic [127:0] ref_sk [11];
  logic [7:0] sb_tab [256];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aes128_key_expand dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in_key (in_key),
    .busy   (busy),
    .valid  (valid),
    .sk0    (sk_out[0]),
    .sk1    (sk_out[1]),
    .sk2    (sk_out[2]),
    .sk3    (sk_out[3]),
    .sk4    (sk_out[4]),
    .sk5    (sk_out[5]),
    .sk6    (sk_out[6]),
    .sk7    (sk_out[7]),
    .sk8    (sk_out[8]),
    .sk9    (sk_out[9]),
    .sk10   (sk_out[10])
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Polynomial multiply in GF(2^8), reduced by 0x11b
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = '0;
    if (x != 0) begin
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]], sb_tab[tmp[31:24]]}
              ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) ref_sk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_schedule(input string tag, input logic [127:0] key);
    model_expand(key);
    for (int r = 0; r < 11; r++) check($sformatf("%s sk%0d", tag, r), sk_out[r], ref_sk[r]);
  endtask

  // Present key and start at a falling edge; return one cycle after accept
  task automatic launch(input string tag, input logic [127:0] key, input bit hold);
    @(negedge clk);
    in_key = key;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    check({tag, " busy@1"}, 128'(busy), 128'd1);
    check({tag, " valid@1"}, 128'(valid), 128'd0);
    check({tag, " sk0@1"}, sk_out[0], key);
  endtask

  // Cycles 2..10 after accept; optional key scrambling and a stray start pulse
  task automatic rounds(input string tag, input bit scramble, input int inject_at, input bit hold);
    for (int k = 1; k < 10; k++) begin
      if (scramble) in_key = {$urandom, $urandom, $urandom, $urandom};
      if (k == inject_at) begin
        start = 1'b1;
        in_key = '0;
      end else if (!hold) begin
        start = 1'b0;
      end
      @(negedge clk);
      check($sformatf("%s busy@%0d", tag, k + 1), 128'(busy), 128'd1);
    end
    if (!hold) start = 1'b0;
    @(negedge clk);
    check({tag, " busy@10"}, 128'(busy), 128'd0);
    check({tag, " valid@10"}, 128'(valid), 128'd1);
  endtask

  initial begin
    logic [127:0] rkey;
    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_ref(8'(i));

    rst = 1'b1;
    start = 1'b0;
    in_key = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 128'(busy), 128'd0);
    check("reset valid", 128'(valid), 128'd0);
    for (int r = 0; r < 11; r++) check($sformatf("reset sk%0d", r), sk_out[r], '0);
    rst = 1'b0;

    // FIPS-197 A.1 key, in_key scrambled every cycle after accept
    launch("a1", KEY_A1, 1'b0);
    rounds("a1", 1'b1, 0, 1'b0);
    check("a1 fips sk0", sk_out[0], KEY_A1);
    check("a1 fips sk1", sk_out[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("a1 fips sk2", sk_out[2], 128'hf2c295f27a96b9435935807a7359f67f);
    check("a1 fips sk4", sk_out[4], 128'hef44a541a8525b7fb671253bdb0bad00);
    check("a1 fips sk9", sk_out[9], 128'hac7766f319fadc2128d12941575c006e);
    check("a1 fips sk10", sk_out[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_schedule("a1", KEY_A1);
    repeat (3) @(negedge clk);
    check("a1 valid hold", 128'(valid), 128'd1);

    // All-zero key
    launch("zero", '0, 1'b0);
    rounds("zero", 1'b0, 0, 1'b0);
    check("zero fips sk1", sk_out[1], 128'h62636363626363636263636362636363);
    check("zero fips sk10", sk_out[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check_schedule("zero", '0);

    // Stray start with zero key at cycle 3 must be ignored
    launch("ign", KEY_A1, 1'b0);
    rounds("ign", 1'b0, 2, 1'b0);
    check_schedule("ign", KEY_A1);
    @(negedge clk);
    check("ign no requeue", 128'(busy), 128'd0);

    // Asynchronous reset in the middle of an expansion
    rkey = {$urandom, $urandom, $urandom, $urandom};
    launch("mid", rkey, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", 128'(busy), 128'd0);
    check("rst valid", 128'(valid), 128'd0);
    for (int r = 0; r < 11; r++) check($sformatf("rst sk%0d", r), sk_out[r], '0);
    #1 rst = 1'b0;
    rkey = {$urandom, $urandom, $urandom, $urandom};
    launch("post", rkey, 1'b0);
    rounds("post", 1'b0, 0, 1'b0);
    check_schedule("post", rkey);

    // start held high: A.1 then zero key back to back
    launch("b2b1", KEY_A1, 1'b1);
    in_key = '0;
    rounds("b2b1", 1'b0, 0, 1'b1);
    check_schedule("b2b1", KEY_A1);
    @(negedge clk);
    start = 1'b0;
    check("b2b2 valid drop", 128'(valid), 128'd0);
    check("b2b2 busy", 128'(busy), 128'd1);
    check("b2b2 sk0", sk_out[0], '0);
    rounds("b2b2", 1'b0, 0, 1'b0);
    check_schedule("b2b2", '0);

    // Random keys
    for (int n = 0; n < 3; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      launch($sformatf("rnd%0d", n), rkey, 1'b0);
      rounds($sformatf("rnd%0d", n), 1'b1, 0, 1'b0);
      check_schedule($sformatf("rnd%0d", n), rkey);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes128_key_expand.md
Name: aes128_key_expand

Overview:
Clocked AES-128 (FIPS-197) key-schedule engine. Takes a 128-bit cipher key and iteratively produces all eleven round keys, sk0..sk10, at one round key per clock. All round keys are held in output registers. It sits ahead of the AES round datapath, which reads any round key once `valid` is high.

Parameters:
- None. Nk=4 and Nr=10 are fixed constants in the shared package.

Ports:
- clk     input   1    system clock; all state updates on the rising edge
- rst     input   1    asynchronous, active-high reset
- start   input   1    request expansion of `in_key`; accepted only when not busy
- in_key  input   128  cipher key; bits [127:96] = w0, [31:0] = w3; big-endian bytes (byte 0 = [127:120])
- busy    output  1    expansion in progress
- valid   output  1    sk0..sk10 hold a complete schedule for the last accepted key
- sk0 … sk10  output  128 each  round keys; sk0 = cipher key, skN = words w[4N..4N+3], w[4N] in [127:96]

Behaviour:
- Reset (async assert, any time, including mid-expansion):
  - busy=0, valid=0, sk0..sk10=0, round counter=0, rcon=8'h01.
- Accept: on a rising edge with start=1 and busy=0:
  - sk0<=in_key, busy<=1, valid<=0, counter<=1, rcon<=8'h01.
  - in_key is sampled only at this edge; later changes have no effect.
- Iterate: each edge while busy, with counter=N (1..10) and prev=sk(N-1):
  - t = SubWord(RotWord(prev[31:0])) XOR {rcon,24'h0}
  - RotWord: bytes (a,b,c,d) -> (b,c,d,a)
  - SubWord: AES S-box applied to each byte
  - w0 = prev[127:96]^t; w1 = prev[95:64]^w0; w2 = prev[63:32]^w1; w3 = prev[31:0]^w2
  - skN <= {w0,w1,w2,w3}; counter<=N+1; rcon<=xtime(rcon)
  - xtime = shift left 1, XOR 8'h1B if the MSB was set
  - rcon sequence: 01,02,04,08,10,20,40,80,1B,36
- Complete: at the edge that writes sk10, busy<=0 and valid<=1.
  - Latency: valid is visible 10 cycles after the accept edge (11 edges including the accept).
  - valid stays high until the next accept or reset.
- start while busy=1: ignored, no queuing.
- start held high continuously: a new expansion starts on the first edge after busy falls.
- Round keys not yet rewritten keep their old values during an expansion. Consumers must gate on `valid`.
- The previous round key is read from its register; exactly one round is computed per cycle.
- Logic: 4 S-box lookups per cycle; no combinational path from inputs to outputs.

Decomposition:
- Package aes128_pkg:
  - constants NK=4, NR=10, RCON_INIT=8'h01
  - function xtime
  - 256-entry S-box constant table
- One sub-module aes_sbox: combinational 8-bit in / 8-bit out S-box lookup, instantiated 4× for SubWord.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c. Required, 10 cycles after accept: valid=1 and
  - sk0=2b7e151628aed2a6abf7158809cf4f3c
  - sk1=a0fafe1788542cb123a339392a6c7605
  - sk2=f2c295f27a96b9435935807a7359f67f
  - sk4=ef44a541a8525b7fb671253bdb0bad00
  - sk9=ac7766f319fadc2128d12941575c006e
  - sk10=d014f9a8c9ee2589e13f0cc8b6630ca6
- All-zero key -> sk1=62636363626363636263636362636363, sk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Pulse start with the A.1 key, then pulse start with the zero key at cycle 3 while busy:
  - second start ignored; A.1 schedule produced; busy falls after exactly 10 cycles.
- Assert rst at cycle 5 of an expansion:
  - busy, valid and all sk immediately 0.
  - A subsequent start produces the correct full schedule.
- Change in_key every cycle after accept:
  - result matches the key sampled at the accept edge.
- Back-to-back (start held high), A.1 key then zero key:
  - valid drops at the second accept.
  - zero-key schedule valid 10 cycles later.
